fpu_ss_csr_ctrl: RTL and testbench

Sequencer and owner of the FP CSR state (frm, fflags, fcsr view) in the FPU subsystem. Tracks in-flight FPU operations and holds off each CSR access until the FPU pipeline has drained, so fflags reads are exact and frm writes never affect already-issued ops. Accrues exception flags from retiring ops and gates new FPU issue while a CSR access is pending. Sits between the offload decoder and the FPU/CSR datapath.

---
 rtl/fpu_ss_csr_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fpu_ss_csr_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_csr_ctrl.sv
// FP CSR sequencer: owns frm/fflags, drains in-flight FPU ops before each CSR access.
// Optional rounding-mode legality flag: define FPU_SS_CSR_CTRL_RM_CHECK_EN.
module fpu_ss_csr_ctrl #(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fpu_issue_valid_i,
   output logic        fpu_issue_ready_o,
   input  logic        fpu_retire_i,
   input  logic [4:0]  fpu_status_i,
   input  logic        csr_req_valid_i,
   output logic        csr_req_ready_o,
   input  logic [1:0]  csr_op_i,
   input  logic [1:0]  csr_addr_i,
   input  logic [31:0] csr_wdata_i,
   output logic        csr_rsp_valid_o,
   output logic [31:0] csr_rdata_o,
   output logic [2:0]  frm_o,
   output logic [4:0]  fflags_o,
   output logic        busy_o,
   output logic        frm_illegal_o
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [1:0] OP_WRITE    = 2'd1;
   localparam logic [1:0] OP_SET      = 2'd2;
   localparam logic [1:0] OP_CLEAR    = 2'd3;
   localparam logic [1:0] ADDR_FFLAGS = 2'd1;
   localparam logic [1:0] ADDR_FRM    = 2'd2;
   localparam logic [1:0] ADDR_FCSR   = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      EXEC  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [2:0]       frm_q, frm_d;
   logic [4:0]       fflags_q, fflags_d;
   logic [1:0]       op_q, addr_q;
   logic [7:0]       wdata_q;

   logic             issue_ready_c;
   logic             issue_fire;
   logic             req_fire;
   logic [7:0]       old_fld;
   logic [7:0]       wd_fld;
   logic [7:0]       new_fld;
   logic             unused_wdata_hi;

   // fcsr only carries 8 bits; upper write-data bits are architecturally ignored
   assign unused_wdata_hi = ^csr_wdata_i[31:8];

   always_comb begin
      issue_ready_c = (state_q == IDLE) && !csr_req_valid_i &&
                      (count_q < CNT_W'(MAX_OUTSTANDING));
      issue_fire    = fpu_issue_valid_i && issue_ready_c;
      req_fire      = csr_req_valid_i && (state_q == IDLE);

      count_d = count_q;
      if (issue_fire && !fpu_retire_i) begin
         count_d = count_q + CNT_W'(1);
      end else if (!issue_fire && fpu_retire_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end

      // Addressed field and write operand, both viewed in an 8-bit fcsr-sized window
      old_fld = 8'h00;
      wd_fld  = 8'h00;
      case (addr_q)
         ADDR_FFLAGS: begin
            old_fld = {3'b000, fflags_q};
            wd_fld  = {3'b000, wdata_q[4:0]};
         end
         ADDR_FRM: begin
            old_fld = {5'b00000, frm_q};
            wd_fld  = {5'b00000, wdata_q[2:0]};
         end
         ADDR_FCSR: begin
            old_fld = {frm_q, fflags_q};
            wd_fld  = wdata_q;
         end
         default: ;
      endcase

      case (op_q)
         OP_WRITE: new_fld = wd_fld;
         OP_SET:   new_fld = old_fld | wd_fld;
         OP_CLEAR: new_fld = old_fld & ~wd_fld;
         default:  new_fld = old_fld;
      endcase

      fflags_d = fflags_q | (fpu_retire_i ? fpu_status_i : 5'b00000);
      frm_d    = frm_q;
      if (state_q == EXEC) begin
         case (addr_q)
            ADDR_FFLAGS: fflags_d         = new_fld[4:0];
            ADDR_FRM:    frm_d            = new_fld[2:0];
            ADDR_FCSR:   {frm_d, fflags_d} = new_fld;
            default: ;
         endcase
      end

      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_fire) begin
               state_d = ((count_q == '0) && !fpu_retire_i) ? EXEC : DRAIN;
            end
         end
         // Registered count: the final retire's flags are already in fflags_q
         DRAIN:   if (count_q == '0) state_d = EXEC;
         EXEC:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         count_q  <= '0;
         frm_q    <= 3'd0;
         fflags_q <= 5'd0;
         op_q     <= 2'd0;
         addr_q   <= 2'd0;
         wdata_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         frm_q    <= frm_d;
         fflags_q <= fflags_d;
         if (req_fire) begin
            op_q    <= csr_op_i;
            addr_q  <= csr_addr_i;
            wdata_q <= csr_wdata_i[7:0];
         end
      end
   end

   assign fpu_issue_ready_o = issue_ready_c;
   assign csr_req_ready_o   = (state_q == IDLE);
   assign busy_o            = (state_q != IDLE);
   assign csr_rsp_valid_o   = (state_q == EXEC);
   assign csr_rdata_o       = (state_q == EXEC) ? {24'h000000, old_fld} : 32'h0000_0000;
   assign frm_o             = frm_q;
   assign fflags_o          = fflags_q;

`ifdef FPU_SS_CSR_CTRL_RM_CHECK_EN
   assign frm_illegal_o = (frm_q >= 3'd5);
`else
   assign frm_illegal_o = 1'b0;
`endif

   retire_underflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(fpu_retire_i && (count_q == '0)))
      else $error("fpu_ss_csr_ctrl: retire with no op outstanding");

endmodule

// File: tb/tb_fpu_ss_csr_ctrl.sv
// Bench for fpu_ss_csr_ctrl: transaction-level model checked every cycle plus directed literals.
module tb_fpu_ss_csr_ctrl;

   localparam int MAXO = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        fpu_issue_valid_i = 1'b0;
   logic        fpu_issue_ready_o;
   logic        fpu_retire_i = 1'b0;
   logic [4:0]  fpu_status_i = '0;
   logic        csr_req_valid_i = 1'b0;
   logic        csr_req_ready_o;
   logic [1:0]  csr_op_i = '0;
   logic [1:0]  csr_addr_i = '0;
   logic [31:0] csr_wdata_i = '0;
   logic        csr_rsp_valid_o;
   logic [31:0] csr_rdata_o;
   logic [2:0]  frm_o;
   logic [4:0]  fflags_o;
   logic        busy_o;
   logic        frm_illegal_o;

   int total = 0;
   int bad   = 0;

   fpu_ss_csr_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .fpu_issue_valid_i (fpu_issue_valid_i),
      .fpu_issue_ready_o (fpu_issue_ready_o),
      .fpu_retire_i      (fpu_retire_i),
      .fpu_status_i      (fpu_status_i),
      .csr_req_valid_i   (csr_req_valid_i),
      .csr_req_ready_o   (csr_req_ready_o),
      .csr_op_i          (csr_op_i),
      .csr_addr_i        (csr_addr_i),
      .csr_wdata_i       (csr_wdata_i),
      .csr_rsp_valid_o   (csr_rsp_valid_o),
      .csr_rdata_o       (csr_rdata_o),
      .frm_o             (frm_o),
      .fflags_o          (fflags_o),
      .busy_o            (busy_o),
      .frm_illegal_o     (frm_illegal_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a CSR request is pending from accept until its response cycle has passed.
   int m_count = 0, m_frm = 0, m_fflags = 0;
   int m_op = 0, m_addr = 0, m_wdata = 0;
   bit m_pend = 0, m_resp = 0;
   int cnt_before, wd_v, new_v;
   bit issue_ok;

   function automatic int oldval(input int addr);
      case (addr)
         1:       return m_fflags;
         2:       return m_frm;
         3:       return m_frm * 32 + m_fflags;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_count = 0; m_frm = 0; m_fflags = 0;
         m_pend = 0; m_resp = 0;
      end else begin
         cnt_before = m_count;
         issue_ok = fpu_issue_valid_i && !m_pend && !csr_req_valid_i && (m_count < MAXO);
         if (m_resp) begin
            wd_v = m_wdata & ((m_addr == 1) ? 31 : (m_addr == 2) ? 7 : 255);
            case (m_op)
               1:       new_v = wd_v;
               2:       new_v = oldval(m_addr) | wd_v;
               3:       new_v = oldval(m_addr) & ~wd_v;
               default: new_v = oldval(m_addr);
            endcase
            if (m_addr == 1) m_fflags = new_v;
            if (m_addr == 2) m_frm = new_v;
            if (m_addr == 3) begin
               m_frm    = (new_v / 32) % 8;
               m_fflags = new_v % 32;
            end
            m_pend = 0;
            m_resp = 0;
         end else if (m_pend) begin
            if (cnt_before == 0) m_resp = 1;
         end else if (csr_req_valid_i) begin
            m_op = int'(csr_op_i); m_addr = int'(csr_addr_i); m_wdata = int'(csr_wdata_i);
            m_pend = 1;
            m_resp = (cnt_before == 0) && !fpu_retire_i;
         end
         if (fpu_retire_i) m_fflags = m_fflags | int'(fpu_status_i);
         if (issue_ok) m_count = m_count + 1;
         if (fpu_retire_i && cnt_before > 0) m_count = m_count - 1;
      end
   end

   // Every-cycle comparison against the model, mid-cycle
   always @(negedge clk_i) begin
      check("issue_ready", 32'(fpu_issue_ready_o),
            32'(!m_pend && !csr_req_valid_i && (m_count < MAXO)));
      check("req_ready", 32'(csr_req_ready_o), 32'(!m_pend));
      check("busy", 32'(busy_o), 32'(m_pend));
      check("rsp_valid", 32'(csr_rsp_valid_o), 32'(m_resp));
      check("rdata", csr_rdata_o, m_resp ? 32'(oldval(m_addr)) : 32'h0);
      check("frm", 32'(frm_o), 32'(m_frm));
      check("fflags", 32'(fflags_o), 32'(m_fflags));
`ifdef FPU_SS_CSR_CTRL_RM_CHECK_EN
      check("frm_illegal", 32'(frm_illegal_o), 32'(m_frm >= 5));
`else
      check("frm_illegal", 32'(frm_illegal_o), 32'h0);
`endif
   end

   task automatic drive(input bit iv, input bit rt, input logic [4:0] st, input bit rv,
                        input logic [1:0] op, input logic [1:0] ad, input logic [31:0] wd);
      fpu_issue_valid_i = iv;
      fpu_retire_i      = rt;
      fpu_status_i      = st;
      csr_req_valid_i   = rv;
      csr_op_i          = op;
      csr_addr_i        = ad;
      csr_wdata_i       = wd;
   endtask

   task automatic idle();
      drive(0, 0, 5'h00, 0, 2'd0, 2'd0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_rsp(input string name, input logic [31:0] exp_rdata);
      check({name, "_rsp"}, 32'(csr_rsp_valid_o), 32'h1);
      check({name, "_rdata"}, csr_rdata_o, exp_rdata);
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // Reset state
      check("lit_rst_issue_ready", 32'(fpu_issue_ready_o), 32'h1);
      check("lit_rst_req_ready", 32'(csr_req_ready_o), 32'h1);
      check("lit_rst_busy", 32'(busy_o), 32'h0);
      check("lit_rst_fcsr", {24'h0, frm_o, fflags_o}, 32'h0);

      // Read fcsr when drained: response the next cycle
      drive(0, 0, 5'h00, 1, 2'd0, 2'd3, 32'h0);
      #1 check("lit_t1_req_ready", 32'(csr_req_ready_o), 32'h1);
      tick();
      check_rsp("lit_t1", 32'h0);
      idle(); tick();
      check("lit_t1_rsp_done", 32'(csr_rsp_valid_o), 32'h0);

      // Three ops in flight, fflags read waits for drain
      drive(1, 0, 5'h00, 0, 2'd0, 2'd0, 32'h0);
      repeat (3) tick();
      drive(0, 0, 5'h00, 1, 2'd0, 2'd1, 32'h0);
      tick();
      check("lit_t2_busy", 32'(busy_o), 32'h1);
      check("lit_t2_no_rsp", 32'(csr_rsp_valid_o), 32'h0);
      drive(1, 0, 5'h00, 0, 2'd0, 2'd0, 32'h0);
      #1 check("lit_t2_issue_blocked", 32'(fpu_issue_ready_o), 32'h0);
      tick();
      drive(0, 1, 5'h01, 0, 2'd0, 2'd0, 32'h0); tick();
      idle(); tick();
      drive(0, 1, 5'h04, 0, 2'd0, 2'd0, 32'h0); tick();
      idle(); tick();
      drive(0, 1, 5'h01, 0, 2'd0, 2'd0, 32'h0); tick();
      check("lit_t2_drain_rsp_wait", 32'(csr_rsp_valid_o), 32'h0);
      check("lit_t2_fflags_acc", 32'(fflags_o), 32'h05);
      idle(); tick();
      check_rsp("lit_t2", 32'h05);
      tick();
      check("lit_t2_idle", 32'(busy_o), 32'h0);

      // Write fcsr; upper bits dropped
      drive(0, 0, 5'h00, 1, 2'd1, 2'd3, 32'hFFFF_FFA3); tick();
      check_rsp("lit_t3", 32'h05);
      idle(); tick();
      check("lit_t3_frm", 32'(frm_o), 32'h5);
      check("lit_t3_fflags", 32'(fflags_o), 32'h03);
`ifdef FPU_SS_CSR_CTRL_RM_CHECK_EN
      check("lit_t3_illegal", 32'(frm_illegal_o), 32'h1);
`else
      check("lit_t3_illegal", 32'(frm_illegal_o), 32'h0);
`endif

      // Set then clear fflags
      drive(0, 0, 5'h00, 1, 2'd2, 2'd1, 32'h10); tick();
      check_rsp("lit_t4_set", 32'h03);
      idle(); tick();
      check("lit_t4_set_val", 32'(fflags_o), 32'h13);
      drive(0, 0, 5'h00, 1, 2'd3, 2'd1, 32'h01); tick();
      check_rsp("lit_t4_clr", 32'h13);
      idle(); tick();
      check("lit_t4_clr_val", 32'(fflags_o), 32'h12);

      // Reserved address: rdata 0, no state change
      drive(0, 0, 5'h00, 1, 2'd1, 2'd0, 32'hFF); tick();
      check_rsp("lit_rsv", 32'h0);
      idle(); tick();
      check("lit_rsv_fcsr", {24'h0, frm_o, fflags_o}, 32'hB2);

      // Write frm to a legal mode
      drive(0, 0, 5'h00, 1, 2'd1, 2'd2, 32'h2); tick();
      check_rsp("lit_frm_wr", 32'h5);
      idle(); tick();
      check("lit_frm_val", 32'(frm_o), 32'h2);
      check("lit_frm_legal", 32'(frm_illegal_o), 32'h0);

      // CSR request beats a same-cycle issue; count stays 0 so response is immediate
      drive(1, 0, 5'h00, 1, 2'd0, 2'd2, 32'h0);
      #1 check("lit_t5_issue_lost", 32'(fpu_issue_ready_o), 32'h0);
      check("lit_t5_req_ready", 32'(csr_req_ready_o), 32'h1);
      tick();
      check_rsp("lit_t5", 32'h2);
      idle(); tick();

      // Issue+retire same cycle keeps count; then fill to the limit
      drive(1, 0, 5'h00, 0, 2'd0, 2'd0, 32'h0); tick();
      drive(1, 1, 5'h00, 0, 2'd0, 2'd0, 32'h0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 5'h00, 0, 2'd0, 2'd0, 32'h0);
         #1 check($sformatf("lit_t6_fill%0d", i), 32'(fpu_issue_ready_o), 32'h1);
         tick();
      end
      #1 check("lit_t6_full", 32'(fpu_issue_ready_o), 32'h0);
      tick();

      // Reset while draining
      drive(0, 0, 5'h00, 1, 2'd0, 2'd1, 32'h0); tick();
      drive(0, 1, 5'h00, 0, 2'd0, 2'd0, 32'h0); tick();
      check("lit_t6_drain_busy", 32'(busy_o), 32'h1);
      idle();
      #2 rst_ni = 1'b0;
      #1;
      check("lit_t6_rst_busy", 32'(busy_o), 32'h0);
      check("lit_t6_rst_frm", 32'(frm_o), 32'h0);
      check("lit_t6_rst_issue_ready", 32'(fpu_issue_ready_o), 32'h1);
      check("lit_t6_rst_req_ready", 32'(csr_req_ready_o), 32'h1);
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      tick();
      check("lit_t6_no_stale_rsp", 32'(csr_rsp_valid_o), 32'h0);
      drive(0, 0, 5'h00, 1, 2'd0, 2'd3, 32'h0); tick();
      check_rsp("lit_t6_post", 32'h0);
      idle(); tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
